// File: rtl/snake_pkg.sv
// Shared types and direction encoding for the snake controller and datapath.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [3:0] DIR_RIGHT = 4'b1000;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  // True when a and b point in opposite directions along the same axis.
  function automatic logic is_reverse(input logic [3:0] a, input logic [3:0] b);
    return ((a == DIR_RIGHT) && (b == DIR_LEFT))  ||
           ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
           ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP));
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-cycle rising-edge pulse for an already synchronized level input.
module rise_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // History is forced high during reset so a level held through reset is not seen as an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) d_q <= 1'b1;
    else         d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer: IDLE/PLAY/OVER control, move tick generation, direction filter and score.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter logic [23:0] TICK_START = 24'd12_500_000,
  parameter logic [23:0] TICK_STEP  = 24'd500_000,
  parameter logic [23:0] TICK_MIN   = 24'd3_000_000,
  parameter int          SCORE_W    = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enter_i,
  input  logic [3:0]         btn_i,
  input  logic               snake_colline_i,
  input  logic               apple_colline_i,
  output logic               playing_o,
  output logic               game_over_o,
  output logic [3:0]         direction_o,
  output logic               move_tick_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [23:0]        period_o
);

  state_t               state_q, state_d;
  logic                 enter_rise, apple_rise;
  logic [23:0]          cnt_q, period_q, period_dec;
  logic [SCORE_W-1:0]   score_q;
  logic [3:0]           dir_q, pending_q;
  logic                 start, tick, btn_legal, apple_hit;

  rise_detect u_enter_rise (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (enter_i),
    .rise_o  (enter_rise)
  );

  rise_detect u_apple_rise (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (apple_colline_i),
    .rise_o  (apple_rise)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enter_rise)      state_d = PLAY;
      PLAY:    if (snake_colline_i) state_d = OVER;
      OVER:    if (enter_rise)      state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  assign start     = (state_q == IDLE) && enter_rise;
  // >= rather than == so a period shrink past the running count fires on the next cycle.
  assign tick      = (state_q == PLAY) && (cnt_q >= (period_q - 24'd1));
  assign btn_legal = (state_q == PLAY) && $onehot(btn_i) && !is_reverse(btn_i, dir_q);
  assign apple_hit = (state_q == PLAY) && apple_rise && !snake_colline_i;

  // Compare in 25 bits before subtracting so the period can never underflow.
  assign period_dec = ({1'b0, period_q} >= ({1'b0, TICK_MIN} + {1'b0, TICK_STEP}))
                      ? (period_q - TICK_STEP) : TICK_MIN;

  always_ff @(posedge clk_i) begin
    if (reset_i || start) begin
      cnt_q     <= '0;
      period_q  <= TICK_START;
      score_q   <= '0;
      dir_q     <= DIR_NONE;
      pending_q <= DIR_NONE;
    end else if (state_q == PLAY && !snake_colline_i) begin
      cnt_q <= tick ? 24'd0 : (cnt_q + 24'd1);
      if (btn_legal) pending_q <= btn_i;
      if (tick)      dir_q     <= pending_q;
      if (apple_hit) begin
        score_q  <= (&score_q) ? score_q : (score_q + SCORE_W'(1));
        period_q <= period_dec;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign playing_o   = (state_q == PLAY);
  assign game_over_o = (state_q == OVER);
  assign direction_o = dir_q;
  assign move_tick_o = tick;
  assign score_o     = score_q;
  assign period_o    = period_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed self-checking bench for snake_game_ctrl with a short tick period.
module tb_snake_game_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i, enter_i, snake_colline_i, apple_colline_i;
  logic [3:0] btn_i;
  logic       playing_o, game_over_o, move_tick_o;
  logic [3:0] direction_o;
  logic [9:0] score_o;
  logic [23:0] period_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  snake_game_ctrl #(
    .TICK_START (24'd8),
    .TICK_STEP  (24'd2),
    .TICK_MIN   (24'd4),
    .SCORE_W    (10)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .enter_i         (enter_i),
    .btn_i           (btn_i),
    .snake_colline_i (snake_colline_i),
    .apple_colline_i (apple_colline_i),
    .playing_o       (playing_o),
    .game_over_o     (game_over_o),
    .direction_o     (direction_o),
    .move_tick_o     (move_tick_o),
    .score_o         (score_o),
    .period_o        (period_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Steps at least once, then until move_tick_o is seen; n is the number of steps taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!move_tick_o && n < 64);
    if (!move_tick_o) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL tick_timeout: no move tick within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; enter_i = 1'b0; btn_i = 4'b0000;
    snake_colline_i = 1'b0; apple_colline_i = 1'b0;
    step(); step();
    reset_i = 1'b0;
    tests_run++;
    if ({playing_o, game_over_o, direction_o, move_tick_o} !== 7'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {playing_o, game_over_o, direction_o, move_tick_o});
    end
    tests_run++;
    if (score_o !== 10'd0 || period_o !== 24'd8) begin
      tests_failed++;
      $display("[TB] FAIL reset_score_period: got %0d/%0d expected 0/8", score_o, period_o);
    end
    step();
  endtask

  task automatic test_start();
    int n;
    enter_i = 1'b1; step(); enter_i = 1'b0;
    tests_run++;
    if (playing_o !== 1'b1 || direction_o !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL start: got playing=%b dir=%b expected 1/0000", playing_o, direction_o);
    end
    wait_tick(n);
    tests_run++;
    if (n !== 7) begin
      tests_failed++;
      $display("[TB] FAIL first_tick: got %0d cycles expected 7", n);
    end
    wait_tick(n);
    tests_run++;
    if (n !== 8) begin
      tests_failed++;
      $display("[TB] FAIL tick_spacing: got %0d expected 8", n);
    end
  endtask

  task automatic test_direction();
    int n;
    logic [3:0] presses [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b1001, 4'b0001};
    logic [3:0] expect_dir [6] = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0010};
    step();
    for (int i = 0; i < 6; i++) begin
      btn_i = presses[i]; step();
      // Last case: a second legal press before the tick overrides the first.
      if (i == 5) begin btn_i = 4'b0010; step(); end
      btn_i = 4'b0000;
      wait_tick(n);
      if (i == 0) begin
        tests_run++;
        if (direction_o !== 4'b0000) begin
          tests_failed++;
          $display("[TB] FAIL dir_before_tick: got %b expected 0000", direction_o);
        end
      end
      step();
      tests_run++;
      if (direction_o !== expect_dir[i]) begin
        tests_failed++;
        $display("[TB] FAIL dir_case%0d: got %b expected %b", i, direction_o, expect_dir[i]);
      end
    end
  endtask

  task automatic test_apple();
    int n;
    logic [23:0] exp_period [3] = '{24'd6, 24'd4, 24'd4};
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      apple_colline_i = 1'b1;
      repeat (5) step();
      apple_colline_i = 1'b0;
      tests_run++;
      if (score_o !== 10'(i + 1) || period_o !== exp_period[i]) begin
        tests_failed++;
        $display("[TB] FAIL apple%0d: got score=%0d period=%0d expected %0d/%0d",
                 i, score_o, period_o, i + 1, exp_period[i]);
      end
      wait_tick(n);
      wait_tick(n);
      tests_run++;
      if (n !== int'(exp_period[i])) begin
        tests_failed++;
        $display("[TB] FAIL apple%0d_spacing: got %0d expected %0d", i, n, exp_period[i]);
      end
    end
  endtask

  task automatic test_collision();
    int ticks = 0;
    snake_colline_i = 1'b1; apple_colline_i = 1'b1;
    step();
    snake_colline_i = 1'b0; apple_colline_i = 1'b0;
    tests_run++;
    if ({game_over_o, playing_o, move_tick_o} !== 3'b100 || score_o !== 10'd3 || period_o !== 24'd4) begin
      tests_failed++;
      $display("[TB] FAIL collision: got over/play/tick=%b score=%0d period=%0d expected 100/3/4",
               {game_over_o, playing_o, move_tick_o}, score_o, period_o);
    end
    repeat (10) begin
      step();
      if (move_tick_o) ticks++;
    end
    tests_run++;
    if (ticks !== 0 || score_o !== 10'd3) begin
      tests_failed++;
      $display("[TB] FAIL over_hold: got ticks=%0d score=%0d expected 0/3", ticks, score_o);
    end
    enter_i = 1'b1; step(); enter_i = 1'b0;
    tests_run++;
    if ({game_over_o, playing_o} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL over_to_idle: got %b expected 00", {game_over_o, playing_o});
    end
    step();
    enter_i = 1'b1; step(); enter_i = 1'b0;
    tests_run++;
    if (playing_o !== 1'b1 || score_o !== 10'd0 || period_o !== 24'd8 || direction_o !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL restart: got play=%b score=%0d period=%0d dir=%b expected 1/0/8/0000",
               playing_o, score_o, period_o, direction_o);
    end
  endtask

  task automatic test_reset_midgame();
    repeat (3) step();
    enter_i = 1'b1; reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    tests_run++;
    if ({playing_o, game_over_o, direction_o, move_tick_o} !== 7'b0 || score_o !== 10'd0 || period_o !== 24'd8) begin
      tests_failed++;
      $display("[TB] FAIL midgame_reset: got flags=%b score=%0d period=%0d expected 0/0/8",
               {playing_o, game_over_o, direction_o, move_tick_o}, score_o, period_o);
    end
    repeat (5) step();
    tests_run++;
    if (playing_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL held_enter: got playing=%b expected 0", playing_o);
    end
    enter_i = 1'b0; step();
  endtask

  task automatic test_idle_buttons();
    int n;
    btn_i = 4'b0001; step(); btn_i = 4'b0000;
    enter_i = 1'b1; step(); enter_i = 1'b0;
    wait_tick(n);
    step();
    tests_run++;
    if (direction_o !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL idle_buttons: got %b expected 0000", direction_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_direction();
    test_apple();
    test_collision();
    test_reset_midgame();
    test_idle_buttons();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
